// File: rtl/medicao_scheduler_pkg.sv
// Shared state codes and helpers for the sensor measurement controllers.
// State codes double as the db_estado debug value.
package medicao_scheduler_pkg;

  localparam int unsigned DIST_W = 12;

  localparam logic [3:0] ST_INICIAL  = 4'b0000;
  localparam logic [3:0] ST_ESPERA   = 4'b0001;
  localparam logic [3:0] ST_DISPARA  = 4'b0010;
  localparam logic [3:0] ST_AGUARDA  = 4'b0011;
  localparam logic [3:0] ST_REGISTRA = 4'b0100;
  localparam logic [3:0] ST_FALHA    = 4'b1110;
  localparam logic [3:0] ST_INVALIDO = 4'b1111;

  function automatic int unsigned largura(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic estado_valido(input logic [3:0] s);
    return (s == ST_INICIAL) || (s == ST_ESPERA) || (s == ST_DISPARA) ||
           (s == ST_AGUARDA) || (s == ST_REGISTRA) || (s == ST_FALHA);
  endfunction

endpackage

// File: rtl/medicao_scheduler_if.sv
// Start/done handshake between the scheduler (master) and the sensor interface (slave).
interface medicao_scheduler_if;
  import medicao_scheduler_pkg::*;

  logic              medir;
  logic              pronto;
  logic [DIST_W-1:0] medida;

  modport master (output medir, input pronto, input medida);
  modport slave  (input medir, output pronto, output medida);
endinterface

// File: rtl/medicao_scheduler_contador_m.sv
// Generic modulo-M up counter with synchronous clear (clear wins over enable).
module contador_m
  import medicao_scheduler_pkg::*;
#(
  parameter  int unsigned M = 10,
  localparam int unsigned W = largura(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] valor_o
);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (clr_i) begin
      valor_d = '0;
    end else if (en_i) begin
      valor_d = (valor_q == W'(M - 1)) ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valor_q <= '0;
    else        valor_q <= valor_d;
  end

  assign valor_o = valor_q;

endmodule

// File: rtl/medicao_scheduler.sv
// Periodic/manual distance measurement scheduler with timeout, retries and threshold alarm.
//   state       | meaning
//   INICIAL     | idle, waits for ligar or medir_manual
//   ESPERA      | periodic wait between automatic measurements
//   DISPARA     | one-cycle medir pulse to the sensor
//   AGUARDA     | waiting for pronto, bounded by TIMEOUT
//   REGISTRA    | one-cycle nova_medida after a capture
//   FALHA       | one cycle after all attempts timed out
module medicao_scheduler
  import medicao_scheduler_pkg::*;
#(
  parameter int unsigned       PERIODO  = 5_000_000,
  parameter int unsigned       TIMEOUT  = 2_000_000,
  parameter int unsigned       MAX_TENT = 3,
  parameter logic [DIST_W-1:0] LIMIAR   = 12'd20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ligar_i,
  input  logic                medir_manual_i,
  medicao_scheduler_if.master sensor,
  output logic [DIST_W-1:0]   distancia_o,
  output logic                nova_medida_o,
  output logic                erro_o,
  output logic                alarme_o,
  output logic [3:0]          db_estado_o
);

  localparam int unsigned PW = largura(PERIODO);
  localparam int unsigned TW = largura(TIMEOUT);
  localparam int unsigned NW = largura(MAX_TENT);

  logic [3:0]        estado_q, estado_d;
  logic [NW-1:0]     tent_q, tent_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              erro_q, erro_d;
  logic              alarme_q, alarme_d;
  logic [PW-1:0]     per_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              per_fim, tmo_fim;

  // Each counter is held at zero outside its own state, so it restarts on entry.
  contador_m #(.M(PERIODO)) u_periodo (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (estado_q != ST_ESPERA),
    .en_i    (estado_q == ST_ESPERA),
    .valor_o (per_cnt)
  );

  contador_m #(.M(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (estado_q != ST_AGUARDA),
    .en_i    (estado_q == ST_AGUARDA),
    .valor_o (tmo_cnt)
  );

  assign per_fim = (per_cnt == PW'(PERIODO - 1));
  assign tmo_fim = (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    estado_d = estado_q;
    tent_d   = tent_q;
    dist_d   = dist_q;
    erro_d   = erro_q;
    alarme_d = alarme_q;
    case (estado_q)
      ST_INICIAL: begin
        if (ligar_i || medir_manual_i) estado_d = ST_DISPARA;
      end
      ST_ESPERA: begin
        if (!ligar_i)                      estado_d = ST_INICIAL;
        else if (medir_manual_i || per_fim) estado_d = ST_DISPARA;
      end
      ST_DISPARA: begin
        estado_d = ST_AGUARDA;
      end
      ST_AGUARDA: begin
        // pronto takes priority over a simultaneous timeout
        if (sensor.pronto) begin
          estado_d = ST_REGISTRA;
          dist_d   = sensor.medida;
          alarme_d = (sensor.medida < LIMIAR);
          erro_d   = 1'b0;
        end else if (tmo_fim) begin
          if (tent_q < NW'(MAX_TENT - 1)) begin
            tent_d   = tent_q + NW'(1);
            estado_d = ST_DISPARA;
          end else begin
            estado_d = ST_FALHA;
            erro_d   = 1'b1;
            alarme_d = 1'b0;
          end
        end
      end
      ST_REGISTRA, ST_FALHA: begin
        tent_d   = '0;
        estado_d = ligar_i ? ST_ESPERA : ST_INICIAL;
      end
      default: begin
        tent_d   = '0;
        estado_d = ST_INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= ST_INICIAL;
      tent_q   <= '0;
      dist_q   <= '0;
      erro_q   <= 1'b0;
      alarme_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      tent_q   <= tent_d;
      dist_q   <= dist_d;
      erro_q   <= erro_d;
      alarme_q <= alarme_d;
    end
  end

  assign sensor.medir  = (estado_q == ST_DISPARA);
  assign nova_medida_o = (estado_q == ST_REGISTRA);
  assign distancia_o   = dist_q;
  assign erro_o        = erro_q;
  assign alarme_o      = alarme_q;
  assign db_estado_o   = estado_valido(estado_q) ? estado_q : ST_INVALIDO;

endmodule

// File: tb/tb_medicao_scheduler.sv
// Directed bench for medicao_scheduler with PERIODO=20, TIMEOUT=10, MAX_TENT=3, LIMIAR=20.
module tb_medicao_scheduler;
  import medicao_scheduler_pkg::*;

  logic              clock;
  logic              reset;
  logic              ligar;
  logic              manual;
  logic [11:0]       distancia;
  logic              nova;
  logic              erro;
  logic              alarme;
  logic [3:0]        db;
  int                n_assert;
  int                n_fail;
  int                n;
  int                cnt;

  medicao_scheduler_if sif ();

  medicao_scheduler #(
    .PERIODO (20),
    .TIMEOUT (10),
    .MAX_TENT(3),
    .LIMIAR  (12'd20)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar_i        (ligar),
    .medir_manual_i (manual),
    .sensor         (sif),
    .distancia_o    (distancia),
    .nova_medida_o  (nova),
    .erro_o         (erro),
    .alarme_o       (alarme),
    .db_estado_o    (db)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks at least once, stops at the first cycle with medir high; returns cycles waited.
  task automatic wait_medir(input int limite, output int ciclos);
    ciclos = 0;
    do begin
      tick();
      ciclos++;
    end while (sif.medir !== 1'b1 && ciclos < limite);
  endtask

  task automatic responder(input int atraso, input logic [11:0] m);
    repeat (atraso) tick();
    sif.pronto = 1'b1;
    sif.medida = m;
    tick();
    sif.pronto = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] d, input logic a);
    chk({tag, "_db"},     db,        ST_REGISTRA);
    chk({tag, "_nova"},   nova,      1'b1);
    chk({tag, "_dist"},   distancia, d);
    chk({tag, "_alarme"}, alarme,    a);
    chk({tag, "_erro"},   erro,      1'b0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    ligar      = 1'b0;
    manual     = 1'b0;
    sif.pronto = 1'b0;
    sif.medida = '0;
    #2 reset = 1'b0;
    repeat (3) tick();
    chk("rst_db", db, 4'b0000);
    chk("rst_medir", sif.medir, 1'b0);
    chk("rst_nova", nova, 1'b0);
    chk("rst_erro", erro, 1'b0);
    chk("rst_alarme", alarme, 1'b0);
    chk("rst_dist", distancia, 0);

    reset = 1'b1;
    cnt = 0;
    repeat (6) begin tick(); if (sif.medir === 1'b1) cnt++; end
    chk("idle_no_medir", cnt, 0);
    chk("idle_db", db, ST_INICIAL);

    // periodic measurement, capture 35
    ligar = 1'b1;
    tick();
    chk("first_medir", sif.medir, 1'b1);
    chk("first_db", db, ST_DISPARA);
    tick();
    chk("aguarda_db", db, ST_AGUARDA);
    chk("medir_one_cycle", sif.medir, 1'b0);
    responder(3, 12'd35);
    check_reg("m35", 12'd35, 1'b0);
    tick();
    chk("espera_db", db, ST_ESPERA);
    chk("nova_one_cycle", nova, 1'b0);
    wait_medir(40, n);
    chk("periodo_gap", n, 20);

    // threshold around LIMIAR
    responder(4, 12'd12);
    check_reg("m12", 12'd12, 1'b1);
    tick();
    wait_medir(40, n);
    responder(2, 12'd50);
    check_reg("m50", 12'd50, 1'b0);
    tick();
    wait_medir(40, n);
    responder(5, 12'd20);
    check_reg("m20", 12'd20, 1'b0);
    tick();
    wait_medir(40, n);
    responder(5, 12'd19);
    check_reg("m19", 12'd19, 1'b1);
    tick();
    wait_medir(40, n);
    chk("periodo_gap2", n, 20);

    // no pronto: three attempts then falha
    wait_medir(40, n);
    chk("retry1_gap", n, 11);
    wait_medir(40, n);
    chk("retry2_gap", n, 11);
    cnt = 0;
    repeat (11) begin tick(); if (sif.medir === 1'b1) cnt++; end
    chk("no_fourth_medir", cnt, 0);
    chk("falha_db", db, ST_FALHA);
    chk("falha_erro", erro, 1'b1);
    chk("falha_alarme", alarme, 1'b0);
    chk("falha_dist_held", distancia, 19);
    chk("falha_nova", nova, 1'b0);
    tick();
    chk("pos_falha_db", db, ST_ESPERA);
    wait_medir(40, n);
    chk("pos_falha_gap", n, 20);
    responder(3, 12'd40);
    check_reg("m40", 12'd40, 1'b0);
    tick();
    wait_medir(40, n);

    // pronto on the timeout cycle wins
    responder(10, 12'd33);
    check_reg("tmo_pronto", 12'd33, 1'b0);

    // pronto outside aguarda is ignored
    ligar = 1'b0;
    tick();
    chk("off_db", db, ST_INICIAL);
    sif.pronto = 1'b1;
    sif.medida = 12'd99;
    tick();
    sif.pronto = 1'b0;
    chk("stray_pronto_dist", distancia, 33);
    chk("stray_pronto_nova", nova, 1'b0);

    // manual measurement from inicial, manual during aguarda ignored
    manual = 1'b1;
    tick();
    manual = 1'b0;
    chk("manual_medir", sif.medir, 1'b1);
    tick();
    manual = 1'b1;
    tick();
    manual = 1'b0;
    chk("manual_in_aguarda_medir", sif.medir, 1'b0);
    chk("manual_in_aguarda_db", db, ST_AGUARDA);
    responder(2, 12'd77);
    check_reg("m77", 12'd77, 1'b0);
    tick();
    chk("manual_back_inicial", db, ST_INICIAL);
    cnt = 0;
    repeat (25) begin tick(); if (sif.medir === 1'b1) cnt++; end
    chk("manual_no_extra_medir", cnt, 0);

    // manual request shortens espera
    ligar = 1'b1;
    tick();
    chk("relig_medir", sif.medir, 1'b1);
    responder(1, 12'd100);
    check_reg("m100", 12'd100, 1'b0);
    tick();
    repeat (4) tick();
    manual = 1'b1;
    tick();
    manual = 1'b0;
    chk("manual_in_espera_medir", sif.medir, 1'b1);

    // async reset during aguarda
    responder(1, 12'd5);
    check_reg("m5", 12'd5, 1'b1);
    tick();
    wait_medir(40, n);
    chk("pre_reset_gap", n, 20);
    tick();
    chk("pre_reset_db", db, ST_AGUARDA);
    #2 reset = 1'b0;
    #1;
    chk("areset_db", db, 4'b0000);
    chk("areset_dist", distancia, 0);
    chk("areset_alarme", alarme, 1'b0);
    chk("areset_erro", erro, 1'b0);
    chk("areset_medir", sif.medir, 1'b0);
    chk("areset_nova", nova, 1'b0);
    ligar = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin tick(); if (sif.medir === 1'b1) cnt++; end
    chk("post_reset_no_medir", cnt, 0);
    ligar = 1'b1;
    tick();
    chk("post_reset_medir", sif.medir, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/medicao_scheduler.md
MEDICAO_SCHEDULER -- requirements
Module: medicao_scheduler

Interface
REQ-001 Parameter PERIODO, default 5_000_000; clock cycles between automatic measurement starts (100 ms at 50 MHz).
REQ-002 Parameter TIMEOUT, default 2_000_000; cycles allowed for pronto after each medir pulse.
REQ-003 Parameter MAX_TENT, default 3; total attempts per measurement before declaring failure.
REQ-004 Parameter LIMIAR, default 12'd20; distance threshold for alarme.
REQ-005 clock  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ligar  input  1  level; high enables periodic measurement.
REQ-008 medir_manual  input  1  one-cycle request for an immediate measurement.
REQ-009 pronto  input  1  end-of-measurement strobe from the sensor interface.
REQ-010 medida  input  12  distance from the sensor interface, valid with pronto.
REQ-011 medir  output  1  one-cycle start pulse to the sensor interface.
REQ-012 distancia  output  12  last successfully captured distance.
REQ-013 nova_medida  output  1  one-cycle strobe, distancia just updated.
REQ-014 erro  output  1  high after a failed measurement, until the next success.
REQ-015 alarme  output  1  high when the last captured distance < LIMIAR.
REQ-016 db_estado  output  4  current state code for debug displays.

Function
REQ-017 FSM states and db_estado codes SHALL be: inicial 0000, espera_periodo 0001, dispara 0010, aguarda 0011, registra 0100, falha 1110; illegal state gives 1111 and returns to inicial.
REQ-018 inicial: ligar=1 or medir_manual=1 -> dispara; otherwise stay.
REQ-019 dispara: medir=1 for this cycle only; timeout counter cleared; -> aguarda unconditionally.
REQ-020 aguarda: timeout counter increments each cycle; pronto=1 -> registra; count reaching TIMEOUT-1 without pronto -> dispara if tentativas < MAX_TENT-1 (tentativas+1), else falha.
REQ-021 pronto and timeout in the same cycle: pronto wins.
REQ-022 On the edge aguarda->registra, distancia <= medida, alarme <= (medida < LIMIAR), erro <= 0.
REQ-023 registra: nova_medida=1 for this cycle only; tentativas cleared; -> espera_periodo if ligar else inicial.
REQ-024 On the edge into falha, erro <= 1 and alarme <= 0; distancia is held; falha lasts one cycle, clears tentativas, -> espera_periodo if ligar else inicial.
REQ-025 espera_periodo: period counter cleared on entry and incremented each cycle; ligar=0 -> inicial (highest priority); else medir_manual=1 or count = PERIODO-1 -> dispara.
REQ-026 medir_manual in dispara, aguarda, registra or falha SHALL be ignored, not queued.
REQ-027 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap within a state.
REQ-028 pronto outside aguarda SHALL be ignored.

Reset
REQ-029 reset=0 SHALL force inicial, clear all counters and tentativas, and drive medir, nova_medida, erro, alarme, distancia=0, db_estado=0000 asynchronously, including mid-measurement.
REQ-030 After reset release, no medir pulse before ligar or medir_manual is sampled high.

Structure
REQ-031 State encodings and db_estado codes SHALL be defined in the shared package/include used by the team's other sensor controllers.
REQ-032 Period and timeout counters SHALL each be an instance of one generic modulo counter sub-module, contador_m.

Verification (PERIODO=20, TIMEOUT=10, MAX_TENT=3, LIMIAR=20)
REQ-033 ligar=1 and pronto with medida=35, 4 cycles after medir -> distancia=35, nova_medida one cycle, alarme=0, next medir 20 cycles after entering espera_periodo.
REQ-034 medida=12 -> alarme=1; following measurement medida=50 -> alarme=0.
REQ-035 No pronto ever -> exactly 3 medir pulses, 10 cycles apart in aguarda, then erro=1, distancia held; later success with medida=40 clears erro.
REQ-036 ligar=0, medir_manual pulse in inicial -> one measurement, return to inicial; medir_manual during aguarda -> no extra medir.
REQ-037 pronto coincident with the timeout cycle -> registra taken, no retry medir.
REQ-038 reset=0 asserted during aguarda -> all outputs 0 immediately, db_estado=0000, no medir until ligar is sampled high again.
